// File: rtl/fixed_divider.sv
// Sequential signed fixed-point divider: restoring division on magnitudes, one quotient bit per clock.
// Define FIXED_DIVIDER_ROUND_EN for round-half-away-from-zero; otherwise the result truncates toward zero.
module fixed_divider #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned FRACTION  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [WORD_SIZE-1:0] i_A,
  input  logic [WORD_SIZE-1:0] i_B,
  output logic [WORD_SIZE-1:0] o_quot,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_div_zero
);

  localparam int unsigned W     = WORD_SIZE;
  localparam int unsigned N     = WORD_SIZE + FRACTION;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0] MAX_Q   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_Q   = {1'b1, {(W-1){1'b0}}};
  localparam logic [N:0]   MAX_MAG = (N+1)'(MAX_Q);
  localparam logic [N:0]   MIN_MAG = (N+1)'(MIN_Q);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     mag_b_q, mag_b_d;
  logic [N-1:0]     num_q, num_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [W:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             a_neg_q, a_neg_d;
  logic             dz_q, dz_d;
  logic [W-1:0]     quot_q, quot_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dz_out_q, dz_out_d;

  logic [W-1:0]     mag_a_c, mag_b_c;
  logic [W+1:0]     rem_shift_c, diff_c;
  logic [N:0]       mag_r_c;
  logic [W-1:0]     res_c;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mag_b_q  <= '0;
      num_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      quot_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mag_b_q  <= mag_b_d;
      num_q    <= num_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      a_neg_q  <= a_neg_d;
      dz_q     <= dz_d;
      quot_q   <= quot_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      dz_out_q <= dz_out_d;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mag_b_d  = mag_b_q;
    num_d    = num_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    a_neg_d  = a_neg_q;
    dz_d     = dz_q;
    quot_d   = quot_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    dz_out_d = dz_out_q;

    // 0x8000 keeps magnitude 0x8000 as an unsigned W-bit value
    mag_a_c = a_q[W-1] ? (~a_q + W'(1)) : a_q;
    mag_b_c = b_q[W-1] ? (~b_q + W'(1)) : b_q;

    rem_shift_c = {rem_q, num_q[N-1]};
    diff_c      = rem_shift_c - (W+2)'(mag_b_q);

`ifdef FIXED_DIVIDER_ROUND_EN
    mag_r_c = {1'b0, quo_q} + (N+1)'(({rem_q, 1'b0} >= (W+2)'(mag_b_q)));
`else
    mag_r_c = {1'b0, quo_q};
`endif

    if (!sign_q && (mag_r_c > MAX_MAG)) begin
      res_c = MAX_Q;
    end else if (sign_q && (mag_r_c > MIN_MAG)) begin
      res_c = MIN_Q;
    end else if (sign_q) begin
      res_c = ~mag_r_c[W-1:0] + W'(1);
    end else begin
      res_c = mag_r_c[W-1:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = i_A;
          b_d     = i_B;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d  = a_q[W-1] ^ b_q[W-1];
        a_neg_d = a_q[W-1];
        mag_b_d = mag_b_c;
        num_d   = {mag_a_c, {FRACTION{1'b0}}};
        if (mag_b_c == '0) begin
          dz_d    = 1'b1;
          state_d = S_FIX;
        end else begin
          dz_d    = 1'b0;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Trial subtract; a set sign bit means restore
        if (!diff_c[W+1]) begin
          rem_d = diff_c[W:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_shift_c[W:0];
          quo_d = {quo_q[N-2:0], 1'b0};
        end
        num_d = {num_q[N-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d   = dz_q ? (a_neg_q ? MIN_Q : MAX_Q) : res_c;
        dz_out_d = dz_q;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_quot     = quot_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_div_zero = dz_out_q;

endmodule
